// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core (optional perf counters via MULTICYCLE_CTRL_PERF_EN)
module multicycle_ctrl #(
  parameter bit MEM_WAIT = 1'b1,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         imm_src,
  output logic               illegal,
`ifdef MULTICYCLE_CTRL_PERF_EN
  output logic [31:0]        retired,
  output logic [31:0]        stall_cycles,
`endif
  output logic [STATE_W-1:0] state_o
);
  typedef enum logic [STATE_W-1:0] {
    FETCH    = 'd0,
    DECODE   = 'd1,
    MEMADR   = 'd2,
    MEMREAD  = 'd3,
    MEMWB    = 'd4,
    MEMWRITE = 'd5,
    EXECR    = 'd6,
    EXECI    = 'd7,
    ALUWB    = 'd8,
    BEQ      = 'd9,
    JAL      = 'd10
  } state_t;
  state_t state, next;
  logic ready;
  logic [2:0] alu_dec;
  assign ready = MEM_WAIT ? mem_ready : 1'b1;
  assign state_o = state;
  // ALU operation from funct3; subtraction only for register-register ops
  always_comb
    alu_dec = funct3 == 3'b010 ? 3'b101 :
              funct3 == 3'b110 ? 3'b011 :
              funct3 == 3'b111 ? 3'b010 :
              (funct3 == 3'b000 && funct7b5 && state == EXECR) ? 3'b001 : 3'b000;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= FETCH;
    else state <= next;
  // next-state and per-state control strobes; reset forces everything quiet
  always_comb begin
    next = FETCH;
    pc_write = 1'b0;
    adr_src = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_control = 3'b000;
    imm_src = 2'b00;
    illegal = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b = 2'b10;
        result_src = 2'b10;
        pc_write = ready;
        ir_write = ready;
        next = ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src = 2'b10;
        next = (opcode == 7'b0000011 || opcode == 7'b0100011) ? MEMADR :
               opcode == 7'b0110011 ? EXECR :
               opcode == 7'b0010011 ? EXECI :
               opcode == 7'b1100011 ? BEQ :
               opcode == 7'b1101111 ? JAL : FETCH;
        illegal = next == FETCH;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src = opcode == 7'b0100011 ? 2'b01 : 2'b00;
        next = opcode == 7'b0100011 ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next = ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_write = 1'b1;
        next = ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_control = alu_dec;
        next = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_control = alu_dec;
        next = ALUWB;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_control = 3'b001;
        pc_write = zero;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write = 1'b1;
        imm_src = 2'b11;
        next = ALUWB;
      end
      default: next = FETCH;
    endcase
    if (rst) begin
      next = FETCH;
      pc_write = 1'b0;
      adr_src = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      result_src = 2'b00;
      alu_src_a = 2'b00;
      alu_src_b = 2'b00;
      alu_control = 3'b000;
      imm_src = 2'b00;
      illegal = 1'b0;
    end
  end
`ifdef MULTICYCLE_CTRL_PERF_EN
  // retire on every completing return to FETCH; count memory wait cycles
  always_ff @(posedge clk)
    if (rst) begin
      retired <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == MEMWB || state == ALUWB || state == BEQ || (state == MEMWRITE && ready))
        retired <= retired + 32'd1;
      if ((state == FETCH || state == MEMREAD || state == MEMWRITE) && !ready)
        stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] retired, stall_cycles;
`endif
  int checks = 0;
  int errors = 0;
  logic [20:0] sb[$];
  logic [20:0] got;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal),
`ifdef MULTICYCLE_CTRL_PERF_EN
    .retired(retired), .stall_cycles(stall_cycles),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign got = {state_o, pc_write, adr_src, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};

  function automatic logic [20:0] v(input int st, pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill);
    v = {st[3:0], pcw[0], adr[0], mw[0], irw[0], rw[0], rs[1:0], a[1:0], b[1:0], alu[2:0], imm[1:0], ill[0]};
  endfunction

  function automatic logic [20:0] f_ok();   return v(0,1,0,0,1,0,2,0,2,0,0,0); endfunction
  function automatic logic [20:0] f_wait(); return v(0,0,0,0,0,0,2,0,2,0,0,0); endfunction
  function automatic logic [20:0] dec(input int ill); return v(1,0,0,0,0,0,0,1,1,0,2,ill); endfunction

  task automatic load(input logic [31:0] ins);
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7b5 = ins[30];
  endtask

  task automatic step(input string name, input logic rdy, input logic z);
    logic [20:0] e;
    mem_ready = rdy;
    zero = z;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, got, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (got[16:0] !== 17'd0) begin
      errors++;
      $display("FAIL reset_strobes: got %h expected 0", got[16:0]);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (got !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", got);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    load(32'hFFC4A303);
    sb.push_back(f_ok());
    sb.push_back(dec(0));
    sb.push_back(v(2,0,0,0,0,0,0,2,1,0,0,0));
    sb.push_back(v(3,0,1,0,0,0,0,0,0,0,0,0));
    sb.push_back(v(4,0,0,0,0,1,1,0,0,0,0,0));
    repeat (5) step("lw", 1'b1, 1'b0);
  endtask

  task automatic test_sw();
    load(32'h0064A423);
    sb.push_back(f_ok());
    sb.push_back(dec(0));
    sb.push_back(v(2,0,0,0,0,0,0,2,1,0,1,0));
    sb.push_back(v(5,0,1,1,0,0,0,0,0,0,0,0));
    repeat (4) step("sw", 1'b1, 1'b0);
  endtask

  task automatic test_beq();
    load(32'h00208463);
    for (int z = 1; z >= 0; z--) begin
      sb.push_back(f_ok());
      sb.push_back(dec(0));
      sb.push_back(v(9,z,0,0,0,0,0,2,0,1,0,0));
      repeat (3) step(z ? "beq_taken" : "beq_not_taken", 1'b1, z[0]);
    end
  endtask

  task automatic test_alu();
    logic [31:0] ins[6] = '{32'h40208033, 32'h40208013, 32'h0020E033, 32'h0020A033, 32'h0020F013, 32'h0020C033};
    int st[6]  = '{6, 7, 6, 6, 7, 6};
    int alu[6] = '{1, 0, 3, 5, 2, 0};
    for (int i = 0; i < 6; i++) begin
      load(ins[i]);
      sb.push_back(f_ok());
      sb.push_back(dec(0));
      sb.push_back(v(st[i],0,0,0,0,0,0,2,st[i] == 7 ? 1 : 0,alu[i],0,0));
      sb.push_back(v(8,0,0,0,0,1,0,0,0,0,0,0));
      repeat (4) step("alu_op", 1'b1, 1'b0);
    end
    load(32'h008000EF);
    sb.push_back(f_ok());
    sb.push_back(dec(0));
    sb.push_back(v(10,1,0,0,0,0,0,1,2,0,3,0));
    sb.push_back(v(8,0,0,0,0,1,0,0,0,0,0,0));
    repeat (4) step("jal", 1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    load(32'h00000000);
    sb.push_back(f_ok());
    sb.push_back(dec(1));
    sb.push_back(f_wait());
    step("illegal_fetch", 1'b1, 1'b0);
    step("illegal_decode", 1'b1, 1'b0);
    step("illegal_return", 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    load(32'hFFC4A303);
    sb.push_back(f_ok());
    sb.push_back(dec(0));
    sb.push_back(v(2,0,0,0,0,0,0,2,1,0,0,0));
    repeat (4) sb.push_back(v(3,0,1,0,0,0,0,0,0,0,0,0));
    sb.push_back(v(4,0,0,0,0,1,1,0,0,0,0,0));
    repeat (3) step("lw_stall_pre", 1'b1, 1'b0);
    repeat (3) step("lw_stall_wait", 1'b0, 1'b0);
    step("lw_stall_done", 1'b1, 1'b0);
    step("lw_stall_wb", 1'b1, 1'b0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd3 || retired !== 32'd1) begin
      errors++;
      $display("FAIL perf_lw: stall %0d retired %0d expected 3 1", stall_cycles, retired);
    end
`endif
    load(32'h00208463);
    sb.push_back(f_wait());
    sb.push_back(f_wait());
    sb.push_back(f_ok());
    sb.push_back(dec(0));
    sb.push_back(v(9,1,0,0,0,0,0,2,0,1,0,0));
    repeat (2) step("fetch_stall", 1'b0, 1'b1);
    repeat (3) step("fetch_stall_beq", 1'b1, 1'b1);
`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd5 || retired !== 32'd2) begin
      errors++;
      $display("FAIL perf_beq: stall %0d retired %0d expected 5 2", stall_cycles, retired);
    end
`endif
  endtask

  task automatic test_rst_abort();
    load(32'h0064A423);
    sb.push_back(f_ok());
    sb.push_back(dec(0));
    sb.push_back(v(2,0,0,0,0,0,0,2,1,0,1,0));
    sb.push_back(v(5,0,1,1,0,0,0,0,0,0,0,0));
    sb.push_back(v(5,0,0,0,0,0,0,0,0,0,0,0));
    sb.push_back(f_ok());
    repeat (3) step("abort_pre", 1'b1, 1'b0);
    step("abort_memwrite_wait", 1'b0, 1'b0);
    rst = 1'b1;
    step("abort_rst_cycle", 1'b0, 1'b0);
    rst = 1'b0;
    step("abort_fetch", 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_alu();
    test_illegal();
    test_stall();
    test_rst_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It sequences the shared datapath: PC/IR registers, unified memory port, ALU operand muxes, immediate extender select, register file write and result mux. Inputs are decoded instruction fields from IR and the ALU zero flag. Outputs are registered state plus combinational per-state control strobes.

Parameters:
MEM_WAIT, 1, 1 = fetch/memory states honour mem_ready; 0 = mem_ready ignored and treated as always 1.
STATE_W, 4, width of state encoding and of the state_o debug port.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
opcode  in  7  instr[6:0] from IR
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC register load enable
adr_src  out  1  memory address mux: 0 PC, 1 result
mem_write  out  1  memory write strobe
ir_write  out  1  IR/old_pc load enable
reg_write  out  1  register file write enable
result_src  out  2  00 alu_out reg, 01 read data reg, 10 ALU result
alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1 data
alu_src_b  out  2  00 rs2 data, 01 imm_ext, 10 constant 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  extender select: 00 I, 01 S, 10 B, 11 J
illegal  out  1  one-cycle pulse on unsupported opcode
state_o  out  STATE_W  current state, debug

Behaviour:
- Clock port clk; reset port rst, synchronous, active-high. While rst=1 the state is FETCH (0) on the next edge. All strobes are 0 during the rst cycle: pc_write, ir_write, mem_write, reg_write, illegal. Mux selects are 0 during reset.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 return to FETCH on the next edge.
- FETCH: adr_src=0, a=00, b=10, add, result_src=10. ir_write and pc_write are 1 only when mem_ready=1. The FSM holds in FETCH while mem_ready=0, with outputs stable. On mem_ready=1 it goes to DECODE.
- DECODE: a=01, b=01, add, imm_src=10 (precomputes branch target).
  - Opcode 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - Any other opcode: illegal=1 for this cycle, then FETCH.
- MEMADR: a=10, b=01, add. imm_src=01 if opcode=0100011, else 00. Next state is MEMWRITE for a store, otherwise MEMREAD.
- MEMREAD: adr_src=1, result_src=00. Holds while mem_ready=0. On mem_ready=1 goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE: adr_src=1, result_src=00. mem_write=1 for every cycle spent in this state, including wait cycles. Exits to FETCH on mem_ready=1.
- EXECR: a=10, b=00, ALU decode per funct. Next state ALUWB.
- EXECI: a=10, b=01, imm_src=00, ALU decode with funct7b5 ignored (sub never selected). Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BEQ: a=10, b=00, sub, result_src=00. pc_write=zero. Next state FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write=1, imm_src=11. Next state ALUWB (writes PC+4 to rd).
- ALU decode by funct3:
  - 000 -> sub if (EXECR and funct7b5), else add.
  - 010 -> slt.
  - 110 -> or.
  - 111 -> and.
  - Other values -> add.
- Don't-care outputs in any state are driven 0.
- Latency per instruction with mem_ready tied high: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2 cycles.
- rst asserted mid-instruction aborts it: no write strobe fires in the rst cycle, and the FSM is in FETCH the following cycle.

Optional Feature:
MULTICYCLE_CTRL_PERF_EN:
- When defined, adds output ports retired[31:0] and stall_cycles[31:0], both cleared by rst.
- retired increments on entry to FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It does not increment for illegal instructions.
- stall_cycles increments for each cycle in which FETCH, MEMREAD or MEMWRITE holds because mem_ready=0.
- Both counters wrap from 0xFFFFFFFF to 0.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- lw 0xFFC4A303 (opcode 0000011), mem_ready=1 -> states 0,1,2,3,4,0. imm_src=00 in MEMADR. reg_write=1 only in MEMWB with result_src=01.
- sw 0x0064A423 (opcode 0100011) -> states 0,1,2,5,0. imm_src=01 in MEMADR. mem_write=1 exactly one cycle. reg_write never 1.
- beq (opcode 1100011) with zero=1, then zero=0 -> pc_write=1 in BEQ for the first, 0 for the second. alu_control=001 in both.
- R-type sub (funct3=000, funct7b5=1) -> alu_control=001 in EXECR. The same fields with opcode 0010011 -> 000 in EXECI.
- lw with mem_ready low for 3 cycles in MEMREAD -> FSM holds in state 3 for 4 cycles, then MEMWB. With PERF_EN, stall_cycles=3 and retired=1 after completion.
- opcode 0000000 -> illegal=1 in DECODE, then FETCH. Separately, rst=1 during MEMWRITE -> mem_write=0 that cycle and state_o=0 the next cycle.
